// File: rtl/wr_fram_pkg.sv
// wr_fram_pkg
// Shared constants and the burst command record used by the write-side
// pixel packer (wr_fram_pack) and its command FIFO (wr_cmd_fifo).
//   WORDS_PER_LINE : 32-bit words per 256-bit buffer line
//   BUF_LINES      : lines in the ring buffer
//   BURST_LINES    : lines per full DDR burst
//   cmd_t          : {last, len[5:0], addr[8:0]}, 16 bits
package wr_fram_pkg;

    localparam int WORDS_PER_LINE = 8;
    localparam int BUF_LINES      = 512;
    localparam int BURST_LINES    = 32;
    localparam int CMD_WIDTH      = 16;

    typedef struct packed {
        logic       last;
        logic [5:0] len;
        logic [8:0] addr;
    } cmd_t;

endpackage

// File: rtl/wr_cmd_fifo.sv
// wr_cmd_fifo
// Synchronous first-word-fall-through FIFO holding burst commands.
// The head entry is presented on o_head whenever o_empty is low.
// A push while full is accepted only if a pop happens in the same cycle.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_push, i_push_data: write request and data
//   i_pop              : consume head (ignored when empty)
//   o_head             : current head entry
//   o_full, o_empty    : occupancy flags
module wr_cmd_fifo
    import wr_fram_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = CMD_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    // Pointers wrap naturally, so DEPTH must be a power of two.
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{PTR_W{1'b0}}, w_do_push} - {{PTR_W{1'b0}}, w_do_pop};
        end
    end

endmodule

// File: rtl/wr_fram_pack.sv
// wr_fram_pack
// Packs 16-bit pixels into 32-bit words, writes them into a 512 x 256-bit
// ring buffer (addressed as 4096 x 32-bit words), tracks buffer occupancy
// and issues burst commands for the downstream DDR write engine.
//   wr_clk, wr_rst          : clock, synchronous active-high reset
//   vs_in, de_in, pix_in    : video input (vs rising edge closes a frame)
//   buf_wr_data/addr/en     : buffer write port, addr = {line, word}
//   cmd_valid/addr/len/last : head of the command FIFO
//   cmd_ack                 : head consumed, its lines are freed
//   overflow                : sticky, set when a pair or a command is dropped
//   frame_start             : one-cycle pulse when the next frame begins
module wr_fram_pack
    import wr_fram_pkg::*;
#(
    parameter int PIX_WIDTH   = 16,
    parameter int BUF_LINES   = 512,
    parameter int BURST_LINES = 32,
    parameter int CMD_DEPTH   = 16
) (
    input  logic                   wr_clk,
    input  logic                   wr_rst,
    input  logic                   vs_in,
    input  logic                   de_in,
    input  logic [PIX_WIDTH-1:0]   pix_in,
    output logic [2*PIX_WIDTH-1:0] buf_wr_data,
    output logic [11:0]            buf_wr_addr,
    output logic                   buf_wr_en,
    output logic                   cmd_valid,
    output logic [8:0]             cmd_addr,
    output logic [5:0]             cmd_len,
    output logic                   cmd_last,
    input  logic                   cmd_ack,
    output logic                   overflow,
    output logic                   frame_start
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_PAD  = 2'd1;
    localparam logic [1:0] ST_PUSH = 2'd2;

    // Address fields are fixed at 9 line bits and 3 word bits; BUF_LINES
    // is expected to stay at 2^9.
    localparam logic [9:0] FULL_LINES = 10'(BUF_LINES);
    localparam logic [2:0] LAST_WORD  = 3'(WORDS_PER_LINE - 1);

    logic [1:0]           r_state;
    logic                 r_vs_d;
    logic                 r_half;
    logic [PIX_WIDTH-1:0] r_pix1;
    logic [11:0]          r_waddr;
    logic [8:0]           r_start_line;
    logic [9:0]           r_lines_used;
    logic [5:0]           r_lines_in_burst;
    logic                 r_push;
    cmd_t                 r_push_cmd;

    logic       w_vs_rise;
    logic       w_buf_full;
    logic       w_in_run;
    logic       w_in_pad;
    logic       w_in_push;
    logic       w_pair_wr;
    logic       w_pair_drop;
    logic       w_pad_wr;
    logic       w_pad_drop;
    logic       w_pad_done;
    logic       w_line_done;
    logic       w_burst_full;
    logic [11:0] w_next_addr;
    cmd_t       w_head;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic [5:0] w_pop_len;
    logic       w_fifo_drop;

    assign w_vs_rise  = vs_in & ~r_vs_d;
    assign w_buf_full = (r_lines_used == FULL_LINES);
    assign w_in_run   = (r_state == ST_RUN);
    assign w_in_pad   = (r_state == ST_PAD);
    assign w_in_push  = (r_state == ST_PUSH);

    // A pair completes on the second pixel; it is dropped when every line
    // of the ring is still waiting to be read out.
    assign w_pair_wr   = w_in_run & de_in & r_half & ~w_buf_full;
    assign w_pair_drop = w_in_run & de_in & r_half &  w_buf_full;

    // End of frame: flush a pending half word, then close any partial line
    // so the next frame starts on a line boundary. A leftover half word or
    // a non-zero word index both mean the current line is partial.
    assign w_pad_wr   = w_in_pad & r_half & ~w_buf_full;
    assign w_pad_drop = w_in_pad & r_half &  w_buf_full;
    assign w_pad_done = w_in_pad & ~w_buf_full & (r_half | (r_waddr[2:0] != 3'd0));

    assign w_line_done  = (w_pair_wr & (r_waddr[2:0] == LAST_WORD)) | w_pad_done;
    assign w_burst_full = w_line_done & (r_lines_in_burst == 6'(BURST_LINES - 1));

    always_comb begin
        w_next_addr = r_waddr;
        if (w_pad_done) begin
            w_next_addr = {r_waddr[11:3] + 9'd1, 3'b000};
        end else if (w_pair_wr) begin
            w_next_addr = r_waddr + 12'd1;
        end
    end

    assign w_pop       = cmd_ack & ~w_empty;
    assign w_pop_len   = w_pop ? w_head.len : 6'd0;
    assign w_fifo_drop = r_push & w_full & ~w_pop;

    wr_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_WIDTH)
    ) u_fifo (
        .i_clk       (wr_clk),
        .i_rst       (wr_rst),
        .i_push      (r_push),
        .i_push_data (r_push_cmd),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Head fields are forced to zero when nothing is queued.
    assign cmd_valid = ~w_empty;
    assign cmd_addr  = w_empty ? 9'd0 : w_head.addr;
    assign cmd_len   = w_empty ? 6'd0 : w_head.len;
    assign cmd_last  = w_empty ? 1'b0 : w_head.last;

    // Packer, occupancy tracking, burst scheduling and frame FSM. Commands
    // are staged one cycle in r_push so that a full-burst push lines up with
    // the buffer write that completed the burst.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_state          <= ST_RUN;
            r_vs_d           <= 1'b0;
            r_half           <= 1'b0;
            r_pix1           <= '0;
            r_waddr          <= '0;
            r_start_line     <= '0;
            r_lines_used     <= '0;
            r_lines_in_burst <= '0;
            r_push           <= 1'b0;
            r_push_cmd       <= '0;
            buf_wr_en        <= 1'b0;
            buf_wr_data      <= '0;
            buf_wr_addr      <= '0;
            overflow         <= 1'b0;
            frame_start      <= 1'b0;
        end else begin
            r_vs_d    <= vs_in;
            buf_wr_en <= w_pair_wr | w_pad_wr;
            if (w_pair_wr) begin
                buf_wr_data <= {pix_in, r_pix1};
                buf_wr_addr <= r_waddr;
            end else if (w_pad_wr) begin
                buf_wr_data <= {{PIX_WIDTH{1'b0}}, r_pix1};
                buf_wr_addr <= r_waddr;
            end
            r_waddr <= w_next_addr;

            // Line completion and head release may coincide; fold both.
            r_lines_used <= r_lines_used + {9'd0, w_line_done} - {4'd0, w_pop_len};

            if (w_in_run && de_in) begin
                r_half <= ~r_half;
                if (!r_half) begin
                    r_pix1 <= pix_in;
                end
            end else if (w_in_pad) begin
                r_half <= 1'b0;
            end

            if (w_burst_full || w_in_push) begin
                r_lines_in_burst <= '0;
            end else if (w_line_done) begin
                r_lines_in_burst <= r_lines_in_burst + 6'd1;
            end

            if (w_burst_full) begin
                r_start_line <= w_next_addr[11:3];
            end else if (w_in_push) begin
                r_start_line <= r_waddr[11:3];
            end

            r_push          <= w_burst_full | w_in_push;
            r_push_cmd.last <= ~w_burst_full;
            r_push_cmd.len  <= w_burst_full ? 6'(BURST_LINES) : r_lines_in_burst;
            r_push_cmd.addr <= r_start_line;

            frame_start <= w_in_push;
            overflow    <= overflow | w_pair_drop | w_pad_drop | w_fifo_drop;

            case (r_state)
                ST_RUN:  if (w_vs_rise) r_state <= ST_PAD;
                ST_PAD:  r_state <= ST_PUSH;
                ST_PUSH: r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule
